// File: rtl/product_catalog.sv
// product_catalog
//   Keypad {row,col} -> validated price lookup with per-slot stock tracking.
//   A lookup takes two edges (IDLE->LOOKUP->HOLD); results are held until
//   dispense, cancel, or a new id_req. Price/stock tables are rewritable in IDLE.
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   id_req, row, col                lookup request and slot index
//   dispense, cancel                commit / abandon the held item
//   cfg_we, cfg_row, cfg_col,
//   cfg_price, cfg_stock            table write (accepted in IDLE only)
//   id_done                         1-cycle pulse: lookup result valid
//   id_valid, sold_out,
//   val_product, stock_out          held lookup result
//   dispense_ack                    1-cycle pulse: sale committed
//   cfg_err                         1-cycle pulse: table write rejected
module product_catalog #(
  parameter int unsigned ROW_W       = 2,
  parameter int unsigned COL_W       = 2,
  parameter int unsigned PRICE_W     = 4,
  parameter int unsigned STOCK_W     = 4,
  parameter int unsigned INIT_STOCK  = 5,
  parameter int unsigned DEFAULT_MAP = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               id_req,
  input  logic [ROW_W-1:0]   row,
  input  logic [COL_W-1:0]   col,
  input  logic               dispense,
  input  logic               cancel,
  input  logic               cfg_we,
  input  logic [ROW_W-1:0]   cfg_row,
  input  logic [COL_W-1:0]   cfg_col,
  input  logic [PRICE_W-1:0] cfg_price,
  input  logic [STOCK_W-1:0] cfg_stock,
  output logic               id_done,
  output logic               id_valid,
  output logic               sold_out,
  output logic [PRICE_W-1:0] val_product,
  output logic [STOCK_W-1:0] stock_out,
  output logic               dispense_ack,
  output logic               cfg_err
);

  localparam int unsigned IDX_W = ROW_W + COL_W;
  localparam int unsigned DEPTH = 1 << IDX_W;

  typedef enum logic [1:0] {IDLE, LOOKUP, HOLD} state_t;

  state_t state, next_state;

  logic [PRICE_W-1:0] price_tab [DEPTH];
  logic [STOCK_W-1:0] stock_tab [DEPTH];
  logic [IDX_W-1:0]   idx;
  logic [IDX_W-1:0]   cfg_idx;
  logic [PRICE_W-1:0] cur_price;
  logic [STOCK_W-1:0] cur_stock;
  logic               has_price, has_stock;

  logic load_idx, do_cfg, cfg_rej, do_lookup, do_sale, do_clear;

  // Default price map only exists for the 16-entry table.
  function automatic logic [PRICE_W-1:0] default_price(input logic [IDX_W-1:0] i);
    logic [3:0]         k;
    logic [PRICE_W-1:0] p;
    p = '0;
    k = 4'(i);
    if (DEFAULT_MAP != 0 && IDX_W == 4) begin
      case (k)
        4'b0000: p = PRICE_W'(4);
        4'b0100: p = PRICE_W'(8);
        4'b0101: p = PRICE_W'(2);
        4'b1000: p = PRICE_W'(2);
        4'b1001: p = PRICE_W'(5);
        4'b1010: p = PRICE_W'(7);
        4'b1011: p = PRICE_W'(6);
        4'b1100: p = PRICE_W'(4);
        4'b1101: p = PRICE_W'(7);
        default: p = '0;
      endcase
    end
    return p;
  endfunction

  assign cfg_idx   = {cfg_row, cfg_col};
  assign cur_price = price_tab[idx];
  assign cur_stock = stock_tab[idx];
  assign has_price = (cur_price != '0);
  assign has_stock = (cur_stock != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    load_idx   = 1'b0;
    do_cfg     = 1'b0;
    cfg_rej    = 1'b0;
    do_lookup  = 1'b0;
    do_sale    = 1'b0;
    do_clear   = 1'b0;
    case (state)
      IDLE: begin
        do_cfg = cfg_we;
        if (id_req) begin
          load_idx   = 1'b1;
          next_state = LOOKUP;
        end
      end
      LOOKUP: begin
        cfg_rej    = cfg_we;
        do_lookup  = 1'b1;
        next_state = HOLD;
      end
      HOLD: begin
        cfg_rej = cfg_we;
        // A dispense on an invalid item degrades to a cancel.
        if (dispense || cancel) begin
          do_clear   = 1'b1;
          do_sale    = dispense && id_valid;
          next_state = IDLE;
        end else if (id_req) begin
          load_idx   = 1'b1;
          next_state = LOOKUP;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx          <= '0;
      id_done      <= 1'b0;
      id_valid     <= 1'b0;
      sold_out     <= 1'b0;
      val_product  <= '0;
      stock_out    <= '0;
      dispense_ack <= 1'b0;
      cfg_err      <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        price_tab[i] <= default_price(IDX_W'(i));
        stock_tab[i] <= (default_price(IDX_W'(i)) != '0) ? STOCK_W'(INIT_STOCK) : '0;
      end
    end else begin
      id_done      <= do_lookup;
      dispense_ack <= do_sale;
      cfg_err      <= cfg_rej;
      if (load_idx) idx <= {row, col};
      if (do_cfg) begin
        price_tab[cfg_idx] <= cfg_price;
        stock_tab[cfg_idx] <= cfg_stock;
      end
      if (do_lookup) begin
        id_valid    <= has_price && has_stock;
        sold_out    <= has_price && !has_stock;
        val_product <= (has_price && has_stock) ? cur_price : '0;
        stock_out   <= cur_stock;
      end
      if (do_clear) begin
        id_valid    <= 1'b0;
        sold_out    <= 1'b0;
        val_product <= '0;
        stock_out   <= '0;
      end
      if (do_sale) stock_tab[idx] <= stock_tab[idx] - STOCK_W'(1);
    end
  end

endmodule

// File: tb/tb_product_catalog.sv
// Self-checking bench for product_catalog: a reference price/stock model
// produces expected lookup results that are queued on id_req and compared
// when id_done fires.
module tb_product_catalog;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       id_req, dispense, cancel, cfg_we;
  logic [1:0] row, col, cfg_row, cfg_col;
  logic [3:0] cfg_price, cfg_stock;
  logic       id_done, id_valid, sold_out, dispense_ack, cfg_err;
  logic [3:0] val_product, stock_out;

  product_catalog #(
    .ROW_W(2), .COL_W(2), .PRICE_W(4), .STOCK_W(4), .INIT_STOCK(5), .DEFAULT_MAP(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .id_req(id_req), .row(row), .col(col),
    .dispense(dispense), .cancel(cancel), .cfg_we(cfg_we),
    .cfg_row(cfg_row), .cfg_col(cfg_col), .cfg_price(cfg_price), .cfg_stock(cfg_stock),
    .id_done(id_done), .id_valid(id_valid), .sold_out(sold_out),
    .val_product(val_product), .stock_out(stock_out),
    .dispense_ack(dispense_ack), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int price;
    int valid;
    int sold;
    int stock;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   m_price[16];
  int   m_stock[16];
  int   held_valid;
  int   held_idx;
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_price[i] = 0;
    m_price[4'b0000] = 4; m_price[4'b0100] = 8; m_price[4'b0101] = 2;
    m_price[4'b1000] = 2; m_price[4'b1001] = 5; m_price[4'b1010] = 7;
    m_price[4'b1011] = 6; m_price[4'b1100] = 4; m_price[4'b1101] = 7;
    for (int i = 0; i < 16; i++) m_stock[i] = (m_price[i] != 0) ? 5 : 0;
    held_valid = 0;
  endtask

  // Compare every lookup result against the queued expectation.
  always @(posedge clk) begin
    #1;
    if (rst_n === 1'b1 && id_done === 1'b1) begin
      if (sb.size() == 0) begin
        check("spurious_done", 1, 0);
      end else begin
        mon_e = sb.pop_front();
        check("val_product", 32'(val_product), mon_e.price);
        check("id_valid", 32'(id_valid), mon_e.valid);
        check("sold_out", 32'(sold_out), mon_e.sold);
        check("stock_out", 32'(stock_out), mon_e.stock);
      end
    end
  end

  task automatic lookup(input int r, input int c, input bit with_cfg = 0,
                        input int cp = 0, input int cs = 0);
    exp_t e;
    int   i;
    int   n;
    i = r * 4 + c;
    @(negedge clk);
    id_req = 1'b1;
    row    = r[1:0];
    col    = c[1:0];
    if (with_cfg) begin
      cfg_we    = 1'b1;
      cfg_row   = r[1:0];
      cfg_col   = c[1:0];
      cfg_price = cp[3:0];
      cfg_stock = cs[3:0];
      m_price[i] = cp;
      m_stock[i] = cs;
    end
    e.valid = (m_price[i] != 0 && m_stock[i] != 0) ? 1 : 0;
    e.sold  = (m_price[i] != 0 && m_stock[i] == 0) ? 1 : 0;
    e.price = e.valid ? m_price[i] : 0;
    e.stock = m_stock[i];
    sb.push_back(e);
    held_valid = e.valid;
    held_idx   = i;
    @(posedge clk); #1;
    id_req = 1'b0;
    cfg_we = 1'b0;
    if (with_cfg) check("cfg_err_idle", 32'(cfg_err), 0);
    n = 1;
    while (id_done !== 1'b1 && n < 6) begin
      @(posedge clk); #1;
      n++;
    end
    check("latency", n, 2);
  endtask

  task automatic sell(input bit also_req);
    @(negedge clk);
    dispense = 1'b1;
    if (also_req) begin
      id_req = 1'b1;
      row    = 2'(held_idx / 4);
      col    = 2'(held_idx % 4);
    end
    @(posedge clk); #1;
    dispense = 1'b0;
    id_req   = 1'b0;
    check("dispense_ack", 32'(dispense_ack), held_valid);
    check("clear_val", 32'(val_product), 0);
    check("clear_valid", 32'(id_valid), 0);
    if (held_valid != 0) m_stock[held_idx]--;
    held_valid = 0;
    @(posedge clk); #1;
    check("ack_pulse", 32'(dispense_ack), 0);
    if (also_req) begin
      repeat (2) begin
        @(posedge clk); #1;
        check("no_done_after_sale", 32'(id_done), 0);
      end
    end
  endtask

  task automatic do_cancel();
    @(negedge clk);
    cancel = 1'b1;
    @(posedge clk); #1;
    cancel = 1'b0;
    check("cancel_valid", 32'(id_valid), 0);
    check("cancel_ack", 32'(dispense_ack), 0);
    held_valid = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; id_req = 1'b0; dispense = 1'b0; cancel = 1'b0; cfg_we = 1'b0;
    row = '0; col = '0; cfg_row = '0; cfg_col = '0; cfg_price = '0; cfg_stock = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_done", 32'(id_done), 0);
    check("rst_valid", 32'(id_valid), 0);
    check("rst_val", 32'(val_product), 0);
    check("rst_stock", 32'(stock_out), 0);
    check("rst_ack", 32'(dispense_ack), 0);
    check("rst_cfg_err", 32'(cfg_err), 0);
    @(negedge clk); rst_n = 1'b1;

    // Basic lookup, then empty slot with a dispense that must be ignored
    lookup(1, 0);
    do_cancel();
    lookup(0, 1);
    sell(0);
    lookup(0, 0);
    do_cancel();

    // Drain slot 0101 to sold-out
    for (int k = 0; k < 5; k++) begin
      lookup(1, 1);
      sell(0);
    end
    lookup(1, 1);
    sell(0);

    // Write-through on same-edge cfg + lookup; write rejected while holding
    lookup(3, 3, 1, 9, 2);
    @(negedge clk);
    cfg_we = 1'b1; cfg_row = 2'd3; cfg_col = 2'd3; cfg_price = 4'd3; cfg_stock = 4'd7;
    @(posedge clk); #1;
    cfg_we = 1'b0;
    check("cfg_err_hold", 32'(cfg_err), 1);
    @(posedge clk); #1;
    check("cfg_err_pulse", 32'(cfg_err), 0);
    do_cancel();
    lookup(3, 3);

    // dispense beats id_req in HOLD
    sell(1);
    lookup(3, 3);
    do_cancel();

    // Reset during LOOKUP after a dispense
    lookup(1, 0);
    sell(0);
    lookup(1, 0);
    @(negedge clk);
    id_req = 1'b1; row = 2'd1; col = 2'd0;
    @(posedge clk); #1;
    id_req = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("midrst_val", 32'(val_product), 0);
    check("midrst_valid", 32'(id_valid), 0);
    check("midrst_stock", 32'(stock_out), 0);
    check("midrst_sold", 32'(sold_out), 0);
    check("midrst_done", 32'(id_done), 0);
    @(negedge clk); rst_n = 1'b1;
    model_reset();
    lookup(1, 0);
    do_cancel();
    lookup(1, 1);
    do_cancel();
    lookup(3, 3);
    do_cancel();

    repeat (3) @(posedge clk);
    #1;
    check("sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/product_catalog.md
# product_catalog

Parametrised product catalog for the vending machine datapath. It turns a keypad row/column selection into a validated price through a request/done handshake. It also tracks per-slot stock, so a sold-out slot is reported separately from an empty slot. Prices and stock are reprogrammable at run time. It sits between the keypad scanner and the payment/change FSM.

## Interface

- ROW_W, 2, row index width
- COL_W, 2, column index width (table depth = 2^(ROW_W+COL_W))
- PRICE_W, 4, price width; price 0 marks an empty slot
- STOCK_W, 4, per-slot stock counter width
- INIT_STOCK, 5, stock loaded at reset into every slot with a non-zero default price
- DEFAULT_MAP, 1, 1 = load default price map at reset (only when ROW_W+COL_W == 4), 0 = all prices 0

Ports:

- clk  in  1  rising-edge clock, single clock domain
- rst_n  in  1  asynchronous, active-low reset
- id_req  in  1  request lookup of {row,col}; sampled on the clock edge
- row  in  ROW_W  selected row
- col  in  COL_W  selected column
- dispense  in  1  commit sale of the currently held item
- cancel  in  1  abandon the held item
- cfg_we  in  1  write price/stock for {cfg_row,cfg_col}
- cfg_row  in  ROW_W  configuration row
- cfg_col  in  COL_W  configuration column
- cfg_price  in  PRICE_W  new price
- cfg_stock  in  STOCK_W  new stock
- id_done  out  1  one-cycle pulse: lookup result valid
- id_valid  out  1  held item is purchasable
- sold_out  out  1  held slot has a price but stock 0
- val_product  out  PRICE_W  price of held item (0 if invalid)
- stock_out  out  STOCK_W  stock of held slot
- dispense_ack  out  1  one-cycle pulse: sale committed
- cfg_err  out  1  one-cycle pulse: cfg_we rejected

## Operation

- Index is idx = {row,col}; cfg index is {cfg_row,cfg_col}.
- Default map at idx: 0000→4, 0100→8, 0101→2, 1000→2, 1001→5, 1010→7, 1011→6, 1100→4, 1101→7. All other entries are 0.
- Stock reset: INIT_STOCK where default price ≠ 0, otherwise 0.
- FSM states: IDLE, LOOKUP, HOLD.
- IDLE:
  - id_req → latch idx, go LOOKUP.
  - cfg_we → write price and stock for the cfg index; no state change.
- LOOKUP (always 1 cycle):
  - Register val_product = price[idx] if price ≠ 0 and stock ≠ 0, else 0.
  - Register id_valid = (price ≠ 0 && stock ≠ 0).
  - Register sold_out = (price ≠ 0 && stock == 0).
  - Register stock_out = stock[idx].
  - Pulse id_done, go HOLD.
- HOLD: outputs held. Priority order: dispense > cancel > id_req.
  - dispense with id_valid=1 → stock[idx] decrements by 1, dispense_ack pulses, outputs clear, go IDLE.
  - dispense with id_valid=0 → ignored; treated as cancel.
  - cancel → outputs clear, go IDLE.
  - id_req → latch new idx, go LOOKUP.
- cfg_we is accepted only in IDLE. In LOOKUP or HOLD the write is dropped and cfg_err pulses.
- Stock never underflows, because dispense requires stock ≠ 0. cfg_stock is written as-is, no saturation logic.

## Timing

- Reset (async assert, sync-safe deassert) sets FSM=IDLE, all outputs 0 and loads the tables. Reset mid-lookup or mid-HOLD discards the transaction with no stock change.
- id_req sampled at edge k → LOOKUP during cycle k..k+1 → results and id_done visible after edge k+1. Latency is 2 edges, 1-cycle id_done.
- dispense sampled at edge m in HOLD → dispense_ack high and outputs 0 after edge m. The updated stock is readable by a lookup issued at edge m+1.
- cfg_we and id_req together in IDLE: the write completes at the same edge. The lookup in the next cycle sees the new values, including when the index is the same.
- id_req held high continuously in HOLD re-runs the lookup every 2 cycles. Level-high id_req in IDLE is treated the same way.

## Test plan

- Reset, then id_req with {row,col}=0100 → id_done 2 edges later, val_product=8, id_valid=1, stock_out=5.
- Lookup 0001 (empty slot) → val_product=0, id_valid=0, sold_out=0. dispense → no dispense_ack; FSM returns to IDLE.
- Lookup 0101 and dispense 5 times, each time with a fresh lookup. Sixth lookup → id_valid=0, sold_out=1, stock_out=0. dispense → ignored.
- cfg_we {1111, price 9, stock 2} in IDLE together with id_req at 1111 → val_product=9, stock_out=2. cfg_we while in HOLD → cfg_err pulse, table unchanged.
- In HOLD assert dispense and id_req in the same cycle → dispense_ack, stock decremented by exactly 1, no id_done follows.
- Assert rst_n=0 during LOOKUP after a dispense → all outputs 0 immediately; stock tables back to INIT_STOCK after release.
